// File: rtl/bcd_cnt_n.sv
// bcd_cnt_n: synchronous DIGITS-decade BCD up/down counter with parallel load and cascade carry.
// Define BCD_CNT_SAT_EN to hold at all-9s / all-0s instead of wrapping.
module bcd_cnt_n #(
    parameter int DIGITS = 4
) (
    input  logic                  CK,
    input  logic                  nClear,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  CO
);

    logic [3:0] digit_q [DIGITS];
    logic [3:0] digit_d [DIGITS];
    logic       at_terminal;

    function automatic logic [3:0] clamp_digit(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [3:0] inc_digit(input logic [3:0] v);
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] dec_digit(input logic [3:0] v);
        return (v == 4'd0) ? 4'd9 : v - 4'd1;
    endfunction

    always_comb begin : next_state
        logic all9;
        logic all0;
        logic hold_terminal;
        logic low_ok;

        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        all9          = 1'b1;
        all0          = 1'b1;
        hold_terminal = 1'b0;
        low_ok        = 1'b1;
        at_terminal   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            digit_d[k] = digit_q[k];
        end

        for (int k = 0; k < DIGITS; k++) begin
            all9 = all9 & (digit_q[k] == 4'd9);
            all0 = all0 & (digit_q[k] == 4'd0);
        end
        at_terminal = UP ? all9 : all0;

`ifdef BCD_CNT_SAT_EN
        hold_terminal = at_terminal;
`else
        hold_terminal = 1'b0;
`endif

        // A digit steps only when every lower digit is at its rollover value.
        for (int k = 0; k < DIGITS; k++) begin
            if (LOAD) begin
                digit_d[k] = clamp_digit(D[4*k +: 4]);
            end else if (EN && !hold_terminal && low_ok) begin
                digit_d[k] = UP ? inc_digit(digit_q[k]) : dec_digit(digit_q[k]);
            end
            low_ok = low_ok & (UP ? (digit_q[k] == 4'd9) : (digit_q[k] == 4'd0));
        end
    end

    // NOTE: state registers use non-blocking assignments so all digits update together on the edge.
    always_ff @(posedge CK or negedge nClear) begin
        if (!nClear) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_q[k] <= 4'd0;
            end
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_q[k] <= digit_d[k];
            end
        end
    end

    always_comb begin
        Q = '0;
        for (int k = 0; k < DIGITS; k++) begin
            Q[4*k +: 4] = digit_q[k];
        end
    end

    // Gated by nClear so the carry stays low during clear even when EN=1, UP=0.
    assign CO = nClear & EN & ~LOAD & at_terminal;

endmodule

// File: tb/tb_bcd_cnt_n.sv
// tb_bcd_cnt_n: scoreboard bench for bcd_cnt_n (DIGITS=4) plus a two-instance cascade.
// Expected counts come from a decimal integer model of the counter.
module tb_bcd_cnt_n;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;
`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CK;
    logic         clk_run;
    logic         nClear;
    logic         EN;
    logic         UP;
    logic         LOAD;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         CO;

    logic         c_load;
    logic         c_en;
    logic         c_up;
    logic [W-1:0] c_d_lo;
    logic [W-1:0] c_d_hi;
    logic [W-1:0] c_q_lo;
    logic [W-1:0] c_q_hi;
    logic         c_co_lo;
    logic         c_co_hi;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic         co;
    } exp_t;

    exp_t sb[$];
    int   model_val;
    int   vectors;
    int   miscompares;

    bcd_cnt_n #(.DIGITS(DIGITS)) u_dut (
        .CK(CK), .nClear(nClear), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D), .Q(Q), .CO(CO)
    );

    bcd_cnt_n #(.DIGITS(DIGITS)) u_lo (
        .CK(CK), .nClear(nClear), .EN(c_en), .UP(c_up), .LOAD(c_load), .D(c_d_lo),
        .Q(c_q_lo), .CO(c_co_lo)
    );

    bcd_cnt_n #(.DIGITS(DIGITS)) u_hi (
        .CK(CK), .nClear(nClear), .EN(c_co_lo), .UP(c_up), .LOAD(c_load), .D(c_d_hi),
        .Q(c_q_hi), .CO(c_co_hi)
    );

    initial CK = 1'b0;
    always begin
        #5;
        if (clk_run) CK = ~CK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            r = r * 10 + int'(v[4*k +: 4]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drive one cycle's inputs at the falling edge, predict, then compare after the rising edge.
    task automatic apply_edge(input string nm, input logic load, input logic en,
                              input logic up, input logic [W-1:0] d);
        logic co_pre;
        exp_t e;
        exp_t got;
        @(negedge CK);
        LOAD = load;
        EN   = en;
        UP   = up;
        D    = d;
        co_pre = en && !load && (up ? (model_val == MAXV) : (model_val == 0));
        if (load) begin
            model_val = bcd2int(clamp_bcd(d));
        end else if (en) begin
            if (up) model_val = (model_val == MAXV) ? (SAT ? MAXV : 0) : model_val + 1;
            else    model_val = (model_val == 0) ? (SAT ? 0 : MAXV) : model_val - 1;
        end
        e.name = nm;
        e.q    = int2bcd(model_val);
        e.co   = en && !load && (up ? (model_val == MAXV) : (model_val == 0));
        sb.push_back(e);
        #1;
        vectors++;
        if (CO !== co_pre) begin
            miscompares++;
            $display("FAIL %s co_before_edge: got %0b expected %0b", nm, CO, co_pre);
        end
        @(posedge CK);
        #1;
        got = sb.pop_front();
        vectors++;
        if (Q !== got.q) begin
            miscompares++;
            $display("FAIL %s q: got %h expected %h", got.name, Q, got.q);
        end
        vectors++;
        if (CO !== got.co) begin
            miscompares++;
            $display("FAIL %s co_after_edge: got %0b expected %0b", got.name, CO, got.co);
        end
    endtask

    task automatic test_reset();
        nClear = 1'b0;
        EN = 1'b1; UP = 1'b0; LOAD = 1'b0; D = '0;
        c_load = 1'b0; c_en = 1'b0; c_up = 1'b1; c_d_lo = '0; c_d_hi = '0;
        clk_run = 1'b1;
        #1;
        vectors++;
        if (Q !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_q: got %h expected 0000", Q);
        end
        vectors++;
        if (CO !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_co: got %0b expected 0", CO);
        end
        repeat (2) @(posedge CK);
        #1;
        vectors++;
        if (Q !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held_q: got %h expected 0000", Q);
        end
        @(negedge CK);
        EN = 1'b0;
        nClear = 1'b1;
        model_val = 0;
        apply_edge("preload_0123", 1'b1, 1'b0, 1'b1, 16'h0123);

        // Stop the clock low and clear asynchronously between edges.
        @(negedge CK);
        clk_run = 1'b0;
        LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
        #3;
        nClear = 1'b0;
        #1;
        vectors++;
        if (Q !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_clear_q: got %h expected 0000", Q);
        end
        vectors++;
        if (CO !== 1'b0) begin
            miscompares++;
            $display("FAIL async_clear_co: got %0b expected 0", CO);
        end
        #3;
        EN = 1'b0;
        nClear = 1'b1;
        model_val = 0;
        #1;
        vectors++;
        if (Q !== 16'h0000) begin
            miscompares++;
            $display("FAIL release_q: got %h expected 0000", Q);
        end
        clk_run = 1'b1;
        apply_edge("first_up", 1'b0, 1'b1, 1'b1, 16'h0000);
    endtask

    task automatic test_load_count();
        apply_edge("load_0199", 1'b1, 1'b0, 1'b1, 16'h0199);
        apply_edge("up_to_0200", 1'b0, 1'b1, 1'b1, 16'h0000);
        apply_edge("down_to_0199", 1'b0, 1'b1, 1'b0, 16'h0000);
        apply_edge("hold_a", 1'b0, 1'b0, 1'b1, 16'h5555);
        apply_edge("hold_b", 1'b0, 1'b0, 1'b0, 16'h5555);
    endtask

    task automatic test_wrap();
        apply_edge("load_9999", 1'b1, 1'b0, 1'b1, 16'h9999);
        apply_edge("up_at_9999", 1'b0, 1'b1, 1'b1, 16'h0000);
        apply_edge("load_0000", 1'b1, 1'b0, 1'b0, 16'h0000);
        apply_edge("down_at_0000", 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic test_load_clamp();
        apply_edge("load_12AF", 1'b1, 1'b0, 1'b1, 16'h12AF);
        apply_edge("load_en_0500", 1'b1, 1'b1, 1'b1, 16'h0500);
        apply_edge("load_FFFF", 1'b1, 1'b1, 1'b0, 16'hFFFF);
    endtask

    task automatic test_saturate();
        apply_edge("sat_load_9999", 1'b1, 1'b0, 1'b1, 16'h9999);
        for (int i = 0; i < 3; i++) apply_edge("sat_up", 1'b0, 1'b1, 1'b1, 16'h0000);
        apply_edge("sat_load_0000", 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) apply_edge("sat_down", 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic         ld;
            logic         en;
            logic         up;
            logic [W-1:0] d;
            ld = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            d  = W'($urandom);
            apply_edge("random", ld, en, up, d);
        end
        // Ripple across all four decades in both directions.
        apply_edge("ripple_load", 1'b1, 1'b0, 1'b1, 16'h0999);
        apply_edge("ripple_up", 1'b0, 1'b1, 1'b1, 16'h0000);
        apply_edge("ripple_down", 1'b0, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic test_cascade();
        logic [W-1:0] exp_lo;
        @(negedge CK);
        c_load = 1'b1; c_en = 1'b0; c_up = 1'b1;
        c_d_lo = 16'h9998; c_d_hi = 16'h0000;
        @(negedge CK);
        c_load = 1'b0; c_en = 1'b1;
        #1;
        vectors++;
        if (c_co_lo !== 1'b0) begin
            miscompares++;
            $display("FAIL cascade_co_at_9998: got %0b expected 0", c_co_lo);
        end
        @(posedge CK);
        #1;
        vectors++;
        if (c_q_lo !== 16'h9999 || c_q_hi !== 16'h0000) begin
            miscompares++;
            $display("FAIL cascade_edge1: got hi=%h lo=%h expected hi=0000 lo=9999", c_q_hi, c_q_lo);
        end
        vectors++;
        if (c_co_lo !== 1'b1) begin
            miscompares++;
            $display("FAIL cascade_co_at_9999: got %0b expected 1", c_co_lo);
        end
        @(posedge CK);
        #1;
        exp_lo = SAT ? 16'h9999 : 16'h0000;
        vectors++;
        if (c_q_lo !== exp_lo || c_q_hi !== 16'h0001) begin
            miscompares++;
            $display("FAIL cascade_edge2: got hi=%h lo=%h expected hi=0001 lo=%h", c_q_hi, c_q_lo, exp_lo);
        end
        @(negedge CK);
        c_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_val   = 0;
        test_reset();
        test_load_count();
        test_load_clamp();
        if (SAT) test_saturate();
        else     test_wrap();
        test_back_to_back();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_cnt_n.md
# bcd_cnt_n

Parametrised synchronous multi-decade BCD counter with up/down counting, parallel load and cascade carry. It extends the single-decade asynchronous-clear BCD counter to DIGITS decades in one fully synchronous block, so all digits change on the same clock edge with no ripple. It is the counting core for the decimal display and event-tally paths, and wide counts are built by chaining instances through CO/EN.

## Interface
Parameters:
- DIGITS, 4: number of BCD decades (1..8); count range 0 .. 10^DIGITS−1.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- nClear  input  1  asynchronous, active-low reset; clears all digits to 0.
- EN  input  1  count enable; one step per CK edge while high.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous parallel load of D; overrides EN.
- D  input  4*DIGITS  load value; digit k = D[4k+3:4k], digit 0 least significant.
- Q  output  4*DIGITS  count; same digit packing as D.
- CO  output  1  carry/borrow out for cascading (combinational).

## Operation
- Priority: nClear low > LOAD > EN > hold.
- nClear low: Q = 0 immediately, without waiting for CK, and held while low. No count or load while low.
- LOAD=1 at edge: each digit takes its D nibble. A nibble > 9 (A..F) is stored as 9. EN and UP ignored.
- EN=1, LOAD=0, UP=1: digit 0 increments. Digit k increments only when digits 0..k−1 are all 9. A digit at 9 that increments becomes 0.
- EN=1, LOAD=0, UP=0: digit 0 decrements. Digit k decrements only when digits 0..k−1 are all 0. A digit at 0 that decrements becomes 9.
- EN=0, LOAD=0: Q holds.
- CO = EN & ~LOAD & (UP ? all digits 9 : all digits 0). CO connects to the EN of the next instance.
- Every digit of Q is always valid BCD (0..9), including after load. Non-BCD states are unreachable.

## Timing
- Reset values: Q = 0; CO = 0 while nClear is low.
- Release of nClear is asynchronous. The first count or load takes effect at the first CK rising edge after release.
- Count and load latency: Q reflects the new value one CK edge after EN or LOAD is sampled high.
- CO is combinational from Q, EN, UP and LOAD, with no register stage. It is valid within the same cycle as the terminal value.
- Wrap, default build: up at all-9s goes to all-0s; down at all-0s goes to all-9s. CO=1 in the cycle before the wrap.
- Direction change takes effect on the edge at which the new UP is sampled. No extra cycle is added.
- If nClear is asserted in the same cycle as LOAD or EN, clear wins and the load or count is lost.

## Configuration
- BCD_CNT_SAT_EN defined: saturating mode.
  - Up at all-9s holds all-9s; down at all-0s holds all-0s.
  - CO still asserts at the terminal value with EN=1, so a cascaded next stage advances once per terminal cycle.
  - LOAD and nClear are unaffected.
- BCD_CNT_SAT_EN undefined: wrap-around as in Timing.

## Test plan
With DIGITS=4, default build unless stated:
- Pulse nClear low mid-cycle with CK stopped → Q=0x0000 without a CK edge. After release, one edge with EN=1, UP=1 → Q=0x0001.
- LOAD with D=0x0199, then EN=1, UP=1 for 1 edge → Q=0x0200. Down 1 edge → Q=0x0199.
- LOAD 0x9999, EN=1, UP=1 → CO=1 before the edge; after the edge Q=0x0000 and CO=0. Repeat UP=0 from 0x0000 → Q=0x9999.
- LOAD D=0x12AF → Q=0x1299. LOAD=1 and EN=1 together with D=0x0500 → Q=0x0500 with no increment.
- Two instances cascaded via CO→EN, low instance loaded 0x9998 → after 2 edges the high instance reads 0x0001 and the low instance reads 0x0000.
- BCD_CNT_SAT_EN defined, LOAD 0x9999, 3 up edges → Q stays 0x9999 and CO=1 each cycle. Load 0x0000, 3 down edges → Q stays 0x0000.
